// File: rtl/cpu_pkg.sv
// Shared loader definitions: FSM state encoding, stream framing constants
// and the word-address helper.
package cpu_pkg;

  localparam int HDR_BYTES      = 2;
  localparam int BYTES_PER_WORD = 4;
  localparam int LEN_W          = 8 * HDR_BYTES;
  localparam int LANE_W         = $clog2(BYTES_PER_WORD);
  localparam int WORD_W         = 8 * BYTES_PER_WORD;

  typedef enum logic [2:0] {
    ST_LEN_HI,
    ST_LEN_LO,
    ST_DATA,
    ST_CHECK,
    ST_RUN,
    ST_ERROR
  } state_e;

  // Byte address of word idx; wraps modulo 2^32.
  function automatic logic [31:0] word_addr(input logic [31:0] base,
                                            input logic [LEN_W-1:0] idx);
    return base + (32'(idx) * 32'(BYTES_PER_WORD));
  endfunction

endpackage

// File: rtl/byte_packer.sv
// Big-endian byte-to-word packer: holds the earlier bytes of the current word
// and presents the completed word in the same cycle as its final byte.
module byte_packer
  import cpu_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              byte_valid,
  input  logic [7:0]        byte_in,
  output logic [WORD_W-1:0] word_out,
  output logic              word_done
);

  logic [WORD_W-9:0] shift_q, shift_d;
  logic [LANE_W-1:0] lane_q, lane_d;

  always_comb begin
    shift_d = shift_q;
    lane_d  = lane_q;
    if (byte_valid) begin
      shift_d = {shift_q[WORD_W-17:0], byte_in};
      lane_d  = lane_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shift_q <= '0;
      lane_q  <= '0;
    end else begin
      shift_q <= shift_d;
      lane_q  <= lane_d;
    end
  end

  // Earliest byte lands in the top lane.
  assign word_out  = {shift_q, byte_in};
  assign word_done = byte_valid && (lane_q == LANE_W'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/program_loader.sv
// Boot loader: parses a length-prefixed, XOR-checksummed byte stream into
// instruction-memory writes and releases the CPU only on a good image.
module program_loader
  import cpu_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          MAX_WORDS = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        cpu_reset,
  output logic        done,
  output logic        error
);

  state_e             state_q, state_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [LEN_W-1:0]   idx_q, idx_d;
  logic [7:0]         csum_q, csum_d;
  logic               we_q, we_d;
  logic [31:0]        addr_q, addr_d;
  logic [31:0]        wdata_q, wdata_d;
  logic               cpu_reset_q, cpu_reset_d;
  logic               done_q, done_d;
  logic               error_q, error_d;

  logic               pack_valid;
  logic [WORD_W-1:0]  pack_word;
  logic               pack_done;
  logic [LEN_W-1:0]   n_len;

  assign pack_valid = rx_valid && (state_q == ST_DATA);
  assign n_len      = {len_q[LEN_W-9:0], rx_data};

  byte_packer u_packer (
    .clk       (clk),
    .reset     (reset),
    .byte_valid(pack_valid),
    .byte_in   (rx_data),
    .word_out  (pack_word),
    .word_done (pack_done)
  );

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    idx_d   = idx_q;
    csum_d  = csum_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    if (rx_valid) begin
      unique case (state_q)
        ST_LEN_HI: begin
          len_d   = LEN_W'(rx_data);
          csum_d  = csum_q ^ rx_data;
          state_d = ST_LEN_LO;
        end
        ST_LEN_LO: begin
          len_d  = n_len;
          csum_d = csum_q ^ rx_data;
          if (n_len == '0)
            state_d = ST_CHECK;
          else if (32'(n_len) > $unsigned(32'(MAX_WORDS)))
            state_d = ST_ERROR;
          else
            state_d = ST_DATA;
        end
        ST_DATA: begin
          csum_d = csum_q ^ rx_data;
          if (pack_done) begin
            we_d    = 1'b1;
            addr_d  = word_addr(BASE_ADDR, idx_q);
            wdata_d = pack_word;
            idx_d   = idx_q + 1'b1;
            if (idx_q == LEN_W'(len_q - 1'b1))
              state_d = ST_CHECK;
          end
        end
        ST_CHECK: begin
          state_d = (rx_data == csum_q) ? ST_RUN : ST_ERROR;
        end
        default: ;  // RUN and ERROR hold until reset
      endcase
    end
    // Status outputs track the state being entered so they change with it.
    cpu_reset_d = (state_d != ST_RUN);
    done_d      = (state_d == ST_RUN);
    error_d     = (state_d == ST_ERROR);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_LEN_HI;
      len_q       <= '0;
      idx_q       <= '0;
      csum_q      <= '0;
      we_q        <= 1'b0;
      addr_q      <= BASE_ADDR;
      wdata_q     <= '0;
      cpu_reset_q <= 1'b1;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      idx_q       <= idx_d;
      csum_q      <= csum_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      cpu_reset_q <= cpu_reset_d;
      done_q      <= done_d;
      error_q     <= error_d;
    end
  end

  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign cpu_reset = cpu_reset_q;
  assign done      = done_q;
  assign error     = error_q;

endmodule

// File: tb/tb_program_loader.sv
// Randomised bench for program_loader: a byte-count model predicts writes and
// status every cycle, plus literal checks on the directed streams.
module tb_program_loader;

  localparam logic [31:0] BASE = 32'h0000_0000;
  localparam int          MAXW = 1024;

  typedef logic [7:0] byte_q_t[$];

  logic        clk = 1'b0;
  logic        reset;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        cpu_reset;
  logic        done;
  logic        error;

  program_loader #(.BASE_ADDR(BASE), .MAX_WORDS(MAXW)) dut (
    .clk      (clk),
    .reset    (reset),
    .rx_valid (rx_valid),
    .rx_data  (rx_data),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .cpu_reset(cpu_reset),
    .done     (done),
    .error    (error)
  );

  always #5 clk = ~clk;

  int vectors    = 0;
  int miscompares = 0;
  bit chk_en     = 0;

  // Model: bytes accepted so far and the status they imply.
  byte_q_t     mbytes;
  logic [7:0]  mxor;
  int          mn;
  int          mstat;      // 0 loading, 1 run, 2 error
  int          exp_writes;
  logic        exp_we;
  logic [31:0] exp_addr;
  logic [31:0] exp_data;

  logic [31:0] log_addr[$];
  logic [31:0] log_data[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, req, $time);
    end
  endtask

  task automatic model_clear();
    mbytes.delete();
    mxor       = 8'h00;
    mn         = 0;
    mstat      = 0;
    exp_writes = 0;
    exp_we     = 1'b0;
  endtask

  task automatic model_step(input logic v, input logic [7:0] d);
    int m;
    int k;
    exp_we = 1'b0;
    if (!v || mstat != 0) return;
    mbytes.push_back(d);
    mxor ^= d;
    m = mbytes.size();
    if (m == 2) begin
      mn = int'(mbytes[0]) * 256 + int'(mbytes[1]);
      if (mn > MAXW) mstat = 2;
    end else if (m > 2 && m <= 2 + 4 * mn) begin
      if ((m - 2) % 4 == 0) begin
        k        = (m - 2) / 4 - 1;
        exp_we   = 1'b1;
        exp_addr = BASE + 32'(4 * k);
        exp_data = {mbytes[m-4], mbytes[m-3], mbytes[m-2], mbytes[m-1]};
        exp_writes++;
      end
    end else if (m == 3 + 4 * mn) begin
      mstat = (mxor == 8'h00) ? 1 : 2;
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("mem_we", {31'b0, mem_we}, {31'b0, exp_we});
      if (exp_we) begin
        check("mem_addr", mem_addr, exp_addr);
        check("mem_wdata", mem_wdata, exp_data);
      end
      check("done", {31'b0, done}, {31'b0, mstat == 1});
      check("error", {31'b0, error}, {31'b0, mstat == 2});
      check("cpu_reset", {31'b0, cpu_reset}, {31'b0, mstat != 1});
      if (mem_we) begin
        log_addr.push_back(mem_addr);
        log_data.push_back(mem_wdata);
      end
    end
  end

  task automatic cycle(input logic v, input logic [7:0] d);
    rx_valid = v;
    rx_data  = d;
    @(posedge clk);
    #1 model_step(v, d);
    #1 rx_valid = 1'b0;
  endtask

  task automatic send(input byte_q_t b, input int gap);
    foreach (b[i]) begin
      cycle(1'b1, b[i]);
      repeat (gap) cycle(1'b0, 8'h00);
    end
    repeat (2) cycle(1'b0, 8'h00);
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    model_clear();
    log_addr.delete();
    log_data.delete();
    @(negedge clk);
    #1;
    check("rst_we", {31'b0, mem_we}, 32'd0);
    check("rst_addr", mem_addr, BASE);
    check("rst_wdata", mem_wdata, 32'd0);
    check("rst_cpu_reset", {31'b0, cpu_reset}, 32'd1);
    check("rst_done_err", {30'b0, done, error}, 32'd0);
    @(posedge clk);
    #2 reset = 1'b0;
  endtask

  function automatic logic [7:0] xsum(input byte_q_t b);
    logic [7:0] x = 8'h00;
    foreach (b[i]) x ^= b[i];
    return x;
  endfunction

  task automatic build(input int n, output byte_q_t b);
    b.delete();
    b.push_back(8'(n >> 8));
    b.push_back(8'(n));
    for (int i = 0; i < 4 * n; i++) b.push_back(8'($urandom_range(0, 255)));
  endtask

  initial begin
    byte_q_t s;
    logic [7:0] c;
    logic [31:0] w;
    int n;
    int gap;
    chk_en = 1'b1;
    do_reset();

    // One word, back-to-back, then trailing bytes after RUN.
    s = '{8'h00, 8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h23};
    send(s, 0);
    check("a_writes", 32'(log_addr.size()), 32'd1);
    if (log_addr.size() == 1) begin
      check("a_addr", log_addr[0], 32'h0);
      check("a_data", log_data[0], 32'hDEADBEEF);
    end
    check("a_done", {31'b0, done}, 32'd1);
    check("a_cpu_reset", {31'b0, cpu_reset}, 32'd0);
    s = '{8'h00, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44};
    send(s, 0);
    check("a_post_run_writes", 32'(log_addr.size()), 32'd1);

    // Two words with 10 idle cycles between bytes.
    do_reset();
    build(2, s);
    s.push_back(xsum(s));
    send(s, 10);
    check("b_writes", 32'(log_addr.size()), 32'd2);
    if (log_addr.size() == 2) begin
      check("b_addr0", log_addr[0], 32'h0);
      check("b_addr1", log_addr[1], 32'h4);
      check("b_data1", log_data[1], {s[6], s[7], s[8], s[9]});
    end
    check("b_done", {31'b0, done}, 32'd1);

    // Empty image, good and bad checksum.
    do_reset();
    s = '{8'h00, 8'h00, 8'h00};
    send(s, 0);
    check("c_done", {31'b0, done}, 32'd1);
    check("c_writes", 32'(log_addr.size()), 32'd0);
    do_reset();
    s = '{8'h00, 8'h00, 8'h5A};
    send(s, 0);
    check("d_error", {31'b0, error}, 32'd1);
    check("d_cpu_reset", {31'b0, cpu_reset}, 32'd1);

    // Oversized length: error right after the low length byte.
    do_reset();
    cycle(1'b1, 8'h04);
    cycle(1'b1, 8'h01);
    @(negedge clk);
    #1 check("e_error_now", {31'b0, error}, 32'd1);
    s = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    send(s, 0);
    check("e_writes", 32'(log_addr.size()), 32'd0);

    // Reset mid-word, then a fresh one-word image.
    do_reset();
    s = '{8'h00, 8'h01, 8'h11, 8'h22};
    send(s, 0);
    do_reset();
    build(1, s);
    s.push_back(xsum(s));
    send(s, 0);
    check("f_writes", 32'(log_addr.size()), 32'd1);
    if (log_data.size() == 1)
      check("f_data", log_data[0], {s[2], s[3], s[4], s[5]});
    check("f_done", {31'b0, done}, 32'd1);

    // Largest accepted image.
    do_reset();
    build(MAXW, s);
    s.push_back(xsum(s));
    send(s, 0);
    check("g_writes", 32'(log_addr.size()), 32'(MAXW));
    if (log_addr.size() == MAXW)
      check("g_last_addr", log_addr[MAXW-1], BASE + 32'(4 * (MAXW - 1)));
    check("g_done", {31'b0, done}, 32'd1);

    // Random images: sizes, gaps, corrupt checksums, oversized lengths.
    for (int t = 0; t < 30; t++) begin
      do_reset();
      n   = ($urandom_range(0, 9) == 0) ? int'($urandom_range(MAXW + 1, 65535))
                                        : int'($urandom_range(0, 6));
      gap = int'($urandom_range(0, 2));
      if (n > MAXW) begin
        s = '{8'(n >> 8), 8'(n), 8'hAA, 8'h55, 8'h12, 8'h34};
      end else begin
        build(n, s);
        c = xsum(s);
        if ($urandom_range(0, 3) == 0) c ^= 8'($urandom_range(1, 255));
        s.push_back(c);
        for (int i = 0; i < 4; i++) s.push_back(8'($urandom_range(0, 255)));
      end
      send(s, gap);
      check("r_write_count", 32'(log_addr.size()), 32'(exp_writes));
      w = 32'(mstat);
      check("r_terminal", {31'b0, (w != 0)}, 32'd1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/program_loader.md
PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 The block SHALL have parameter BASE_ADDR, default 32'h0000_0000, giving the byte address of the first loaded word.
REQ-002 The block SHALL have parameter MAX_WORDS, default 1024, giving the largest accepted word count.
REQ-003 Port clk  input  1  is the single clock; all state SHALL update on its rising edge.
REQ-004 Port reset  input  1  SHALL be an asynchronous, active-high reset.
REQ-005 Port rx_valid  input  1  SHALL be a one-cycle strobe marking a valid byte on rx_data; there is no backpressure.
REQ-006 Port rx_data  input  8  is the received byte.
REQ-007 Port mem_we  output  1  SHALL be the instruction-memory write strobe.
REQ-008 Port mem_addr  output  32  is the instruction-memory byte address.
REQ-009 Port mem_wdata  output  32  is the instruction-memory write data.
REQ-010 Port cpu_reset  output  1  SHALL hold the CPU in reset while high.
REQ-011 Port done  output  1  SHALL indicate the image loaded with a good checksum and the CPU released.
REQ-012 Port error  output  1  SHALL indicate a rejected image.

Function
REQ-013 The byte stream SHALL be: length high byte, length low byte (16-bit word count N), 4*N data bytes, then one checksum byte.
REQ-014 The FSM SHALL have states LEN_HI, LEN_LO, DATA, CHECK, RUN and ERROR, and SHALL advance only on cycles where rx_valid=1.
REQ-015 Transitions: LEN_HI->LEN_LO; LEN_LO->DATA if 0<N<=MAX_WORDS, ->CHECK if N=0, ->ERROR if N>MAX_WORDS; DATA->CHECK after the last byte of word N-1.
REQ-016 In CHECK, a checksum byte equal to the XOR of all preceding bytes (length bytes included) SHALL move the FSM to RUN; any other value SHALL move it to ERROR.
REQ-017 Data words SHALL be big-endian: the first byte of each group of four goes to mem_wdata[31:24].
REQ-018 mem_we SHALL pulse high for exactly one cycle, in the cycle after the rx_valid carrying a word's fourth byte.
REQ-019 mem_addr and mem_wdata SHALL be valid while mem_we=1, with mem_addr = BASE_ADDR + 4*k for word index k (k = 0..N-1), computed modulo 2^32.
REQ-020 mem_we SHALL be 0 in every state other than the DATA-completion cycle described in REQ-018.
REQ-021 cpu_reset SHALL be 1 in every state except RUN, and SHALL fall in the cycle the FSM enters RUN.
REQ-022 done SHALL be 1 only in RUN; error SHALL be 1 only in ERROR.
REQ-023 RUN and ERROR SHALL be terminal until reset, and rx_valid SHALL be ignored in both.
REQ-024 The byte-lane counter (2 bits) SHALL wrap 3->0 on each completed word; the word counter is 16 bits wide.

Reset
REQ-025 Reset SHALL set: state=LEN_HI, cpu_reset=1, mem_we=0, done=0, error=0, mem_addr=BASE_ADDR, mem_wdata=0, checksum=0, all counters=0.
REQ-026 Reset asserted mid-load SHALL discard any partial word without issuing a write, and the next byte SHALL be treated as the length high byte.

Structure
REQ-027 The FSM state encoding and the protocol constants (header length 2, bytes per word 4) SHALL live in a shared package, cpu_pkg.
REQ-028 The 4-byte shift/pack register with its lane counter SHALL be a single sub-module, byte_packer, instantiated once.
REQ-029 The block SHALL sit upstream of the CPU, and its cpu_reset output SHALL drive the CPU reset input.

Verification
REQ-030 Stream 00 01 DE AD BE EF chk=0x23 -> one mem_we pulse with addr 0x0, data 0xDEADBEEF; then done=1, cpu_reset=0.
REQ-031 Stream 00 02 + 8 data bytes + a correct checksum -> writes at 0x0 and 0x4, in order, then RUN.
REQ-032 Stream 00 00 00 -> no writes, done=1; stream 00 00 5A -> error=1 and cpu_reset stays 1.
REQ-033 Length bytes 04 01 (N=1025 > MAX_WORDS) -> error=1 immediately after the second byte, with no writes.
REQ-034 Reset asserted after 2 of 4 data bytes, then a valid one-word stream -> exactly one write, carrying the new word.
REQ-035 With rx_valid idle for 10 cycles between bytes -> results identical to back-to-back bytes, and bytes sent after RUN cause no writes.
